// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states, default width and magnitude helper for muldiv_seq.
package muldiv_pkg;
   localparam int DEF_WIDTH = 32;
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] SIGN = 2'd2;
   function automatic logic [DEF_WIDTH-1:0] magnitude(input logic [DEF_WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring trial-subtract divide.
module muldiv_step #(parameter int WIDTH = 32) (
   input  logic             div,
   input  logic [WIDTH-1:0] hi_in,
   input  logic [WIDTH-1:0] lo_in,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);
   logic [WIDTH:0] sum, sh, diff;
   always_comb begin
      sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : '0);
      sh = {hi_in, lo_in[WIDTH-1]};
      // diff[WIDTH] is the borrow: set when the shifted remainder is below the divisor
      diff = sh - {1'b0, opnd};
      hi_out = div ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
      lo_out = div ? {lo_in[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_in[WIDTH-1:1]};
   end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative HI/LO multiply/divide sequencer.
// MULDIV_FAST_MUL_EN selects a single-cycle multiplier for MULT/MULTU.
import muldiv_pkg::*;
module muldiv_seq #(parameter int WIDTH = DEF_WIDTH) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   logic [1:0] state;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] acc_hi, acc_lo, opnd, nxt_hi, nxt_lo, res_hi, res_lo, rs_mag, rt_mag;
   logic [2*WIDTH-1:0] prod_n;
   logic is_div, neg_lo, neg_hi, sgn;
   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div(is_div), .hi_in(acc_hi), .lo_in(acc_lo), .opnd(opnd), .hi_out(nxt_hi), .lo_out(nxt_lo)
   );
   assign busy = state != IDLE;
   always_comb begin
      sgn = ~op[0];
      rs_mag = magnitude(rs_val, sgn & rs_val[WIDTH-1]);
      rt_mag = magnitude(rt_val, sgn & rt_val[WIDTH-1]);
      prod_n = -{acc_hi, acc_lo};
      // divide corrects quotient and remainder independently; multiply negates the full product
      res_hi = is_div ? (neg_hi ? -acc_hi : acc_hi) : (neg_lo ? prod_n[2*WIDTH-1:WIDTH] : acc_hi);
      res_lo = is_div ? (neg_lo ? -acc_lo : acc_lo) : (neg_lo ? prod_n[WIDTH-1:0] : acc_lo);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         done <= 1'b0;
         hi <= '0;
         lo <= '0;
      end else begin
         done <= 1'b0;
         if (flush) state <= IDLE;
         else if (state == IDLE) begin
            if (start && op == OP_MTHI) hi <= rs_val;
            if (start && op == OP_MTLO) lo <= rs_val;
            if (start && !op[2]) begin
               acc_hi <= '0;
               acc_lo <= rs_mag;
               opnd <= rt_mag;
               is_div <= op[1];
               // a zero divisor keeps the all-ones quotient unsigned-looking
               neg_lo <= sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]) & |rt_val;
               neg_hi <= sgn & rs_val[WIDTH-1];
               cnt <= '0;
               state <= CALC;
`ifdef MULDIV_FAST_MUL_EN
               if (!op[1]) begin
                  {acc_hi, acc_lo} <= (2*WIDTH)'(rs_mag) * (2*WIDTH)'(rt_mag);
                  state <= SIGN;
               end
`endif
            end
         end else if (state == CALC) begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= SIGN;
         end else begin
            hi <= res_hi;
            lo <= res_lo;
            done <= 1'b1;
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed-vector bench for muldiv_seq with hand-computed HI/LO results.
module tb_muldiv_seq;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0, busy, done;
   logic [2:0] op = 3'd0;
   logic [31:0] rs_val = '0, rt_val = '0, hi, lo;
   int total = 0, bad = 0;
   muldiv_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      tick;
      start = 1'b0;
      check({tag, ".busy_t1"}, 32'(busy), 32'd1);
      repeat (32) tick;
      check({tag, ".busy_t33"}, 32'(busy), 32'd1);
      check({tag, ".done_t33"}, 32'(done), 32'd0);
      tick;
      check({tag, ".done_t34"}, 32'(done), 32'd1);
      check({tag, ".busy_t34"}, 32'(busy), 32'd0);
      check({tag, ".hi"}, hi, ehi);
      check({tag, ".lo"}, lo, elo);
   endtask
   initial begin
      tick;
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.hi", hi, 32'd0);
      check("rst.lo", lo, 32'd0);
      rst = 1'b0;
      tick;
      run("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
      start = 1'b1; op = 3'd5; rs_val = 32'h12345678;
      tick;
      start = 1'b0;
      check("mtlo.lo", lo, 32'h12345678);
      check("mtlo.hi", hi, 32'hFFFFFFFF);
      check("mtlo.done", 32'(done), 32'd0);
      check("mtlo.busy", 32'(busy), 32'd0);
      start = 1'b1; op = 3'd4; rs_val = 32'hCAFEF00D; flush = 1'b1;
      tick;
      start = 1'b0; flush = 1'b0;
      check("mthi_flush.hi", hi, 32'hFFFFFFFF);
      start = 1'b1; op = 3'd4; rs_val = 32'h0BADBEEF;
      tick;
      start = 1'b0;
      check("mthi.hi", hi, 32'h0BADBEEF);
      run("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      tick;
      check("done_pulse", 32'(done), 32'd0);
      run("divu_zero", 3'd3, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
      run("div_zero_neg", 3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
      run("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      run("div_mixed", 3'd2, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);
      start = 1'b1; op = 3'd3; rs_val = 32'd100; rt_val = 32'd9;
      tick;
      start = 1'b0;
      repeat (4) tick;
      start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd3;
      tick;
      start = 1'b0;
      check("ignore.busy", 32'(busy), 32'd1);
      repeat (4) tick;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      check("flush.busy", 32'(busy), 32'd0);
      check("flush.done", 32'(done), 32'd0);
      check("flush.hi", hi, 32'd2);
      check("flush.lo", lo, 32'hFFFFFFF2);
      run("post_flush", 3'd3, 32'd100, 32'd9, 32'd1, 32'd11);
      start = 1'b1; op = 3'd0; rs_val = 32'd5; rt_val = 32'd6;
      tick;
      start = 1'b0;
      repeat (19) tick;
      rst = 1'b1;
      #1;
      check("arst.busy", 32'(busy), 32'd0);
      check("arst.done", 32'(done), 32'd0);
      check("arst.hi", hi, 32'd0);
      check("arst.lo", lo, 32'd0);
      tick;
      rst = 1'b0;
      run("post_rst", 3'd3, 32'd100, 32'd9, 32'd1, 32'd11);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO register pair of the MIPS core. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the decode/execute stage and runs a radix-2 shift-add or shift-subtract datapath over WIDTH cycles. It exposes busy/done so the control unit can stall MFHI/MFLO and back-to-back mult/div operations. It sits beside the ALU and takes rs/rt register-file read data directly.

## Interface
- WIDTH, 32: operand and HI/LO width; iteration count equals WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation code (muldiv_pkg encodings: MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- rs_val  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- rt_val  in  WIDTH  multiplier / divisor.
- flush  in  1  pipeline exception; aborts any in-flight operation.
- busy  out  1  operation in progress; control stalls MFHI/MFLO and new mult/div while high.
- done  out  1  one-cycle pulse when HI/LO receive a mult/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, SIGN. Reset -> IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- IDLE + start + mult/div op: latch |rs|, |rt| (abs only for signed ops), result sign flags, counter=0 -> CALC.
- IDLE + start + MTHI/MTLO: write hi (or lo) with rs_val at that edge; stay IDLE; no busy, no done.
- CALC: one iteration per cycle; counter increments; at counter==WIDTH-1 -> SIGN.
- Multiply: 2*WIDTH-bit shift-add product; MULTU raw, MULT negated if operand signs differ.
- Divide: restoring shift-subtract; quotient -> lo, remainder -> hi. Signed: quotient negated if signs differ, remainder takes the dividend's sign.
- Divide by zero (any signedness): lo=all ones, hi=rs_val as latched, normal latency, no exception.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0; falls out of the magnitude algorithm, no special case.
- SIGN: apply sign correction, write hi/lo, assert done next cycle, -> IDLE.
- start while busy: ignored, no queuing; op/operands are not re-sampled.
- flush: any state -> IDLE on the next edge; hi/lo unchanged; no done. flush together with start in IDLE: start ignored (MTHI/MTLO included).
- rst mid-operation: immediate return to reset values.

## Timing
- start sampled at the edge ending cycle T.
- busy=1 in cycles T+1 .. T+WIDTH+1 (CALC WIDTH cycles, SIGN 1 cycle).
- hi/lo valid and done=1 in cycle T+WIDTH+2 (T+34 for WIDTH=32); state is IDLE in that cycle, so a new start is accepted there (zero bubble).
- MTHI/MTLO: hi/lo visible in cycle T+1.
- Outputs are registered; no combinational input->output path.

## Configuration
- MULDIV_FAST_MUL_EN defined: MULT/MULTU use a single-cycle WIDTH x WIDTH multiplier; CALC skipped; IDLE -> SIGN directly; busy only in T+1; done and result in T+2. Divide unchanged.
- Undefined: all ops iterative as above; no hardware multiplier is inferred.

## Structure
- muldiv_pkg: op encodings, state enum (IDLE/CALC/SIGN), default width constant, helper function for two's-complement magnitude.
- One sub-module muldiv_step: combinational single-iteration datapath (shift-add for multiply, trial subtract for divide, selected by a mode bit); the FSM, counter, sign flags and HI/LO registers stay in muldiv_seq.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at T -> busy T+1..T+33, done at T+34, hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then MTLO 0x12345678 -> lo=0x12345678 next cycle, hi unchanged, no done.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, no hang, done at T+34.
- DIVU 100/9 started; start with MULT at T+5 ignored; flush at T+10 -> busy=0 at T+11, hi/lo keep prior values, no done; new start at T+11 accepted.
- rst asserted at T+20 of a MULT -> busy, done, hi, lo all 0 immediately; after release a DIVU 100/9 gives lo=11, hi=1 at normal latency.
